// File: rtl/pps_gen.sv
// pps_gen -- programmable 1PPS reference generator.
//
// Emits one pulse per epoch of PERIOD i_pclk cycles as a 4-bit word per
// cycle for a 4:1 LVDS serializer, giving 1 ns edge placement at 250 MHz.
// Phase and width changes are staged in a pending register and become
// active only on the first cycle of an epoch.
//
// Ports
//   i_pclk       pixel-rate clock, sole clock
//   i_res        asynchronous active-high reset
//   i_en         generator enable
//   i_cfg_wr     one-cycle config write strobe
//   i_cfg_phase  rising-edge offset from epoch start, 1 ns units
//   i_cfg_width  high time in i_pclk cycles
//   o_cfg_ack    pulses when pending config becomes active (with o_epoch)
//   o_cfg_err    pulses one cycle after a rejected write
//   o_epoch      pulses on the first cycle of every epoch
//   o_dt4b       serializer word, bit 0 transmitted first
//   o_active     high whenever o_dt4b is non-zero
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_OFF  | generator disabled, epoch counter held at 0, no pulse
// ST_IDLE | enabled, waiting for epoch position to reach coarse phase
// ST_HIGH | pulse in flight, width down-counter running

module pps_gen #(
    parameter int unsigned PERIOD    = 250000000,
    parameter int unsigned WIDTH_CYC = 25000000
) (
    input  logic        i_pclk,
    input  logic        i_res,
    input  logic        i_en,
    input  logic        i_cfg_wr,
    input  logic [29:0] i_cfg_phase,
    input  logic [27:0] i_cfg_width,
    output logic        o_cfg_ack,
    output logic        o_cfg_err,
    output logic        o_epoch,
    output logic [3:0]  o_dt4b,
    output logic        o_active
);

    localparam logic [27:0] PER     = 28'(PERIOD);
    localparam logic [27:0] PER_M1  = 28'(PERIOD - 1);
    localparam logic [30:0] PH_LIM  = 31'(4 * PERIOD);
    localparam int unsigned W_RST_I = (WIDTH_CYC == 0) ? 1 :
                                      ((WIDTH_CYC >= PERIOD) ? (PERIOD - 1) : WIDTH_CYC);
    localparam logic [27:0] W_RST   = 28'(W_RST_I);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_IDLE = 2'd1,
        ST_HIGH = 2'd2
    } state_t;

    state_t      state_q, state_nx;
    logic [27:0] ep_q, ep_nx;
    logic [27:0] cnt_q, cnt_nx;
    logic [1:0]  fine_q, fine_nx;
    logic [29:0] act_phase_q, act_phase_nx;
    logic [27:0] act_width_q, act_width_nx;
    logic [29:0] pend_phase_q, pend_phase_nx;
    logic [27:0] pend_width_q, pend_width_nx;
    logic        pend_q, pend_nx;
    logic [3:0]  word_nx;
    logic        epoch_nx, ack_nx, err_nx;

    logic        wr_ok;
    logic [27:0] wr_width;
    logic [29:0] eff_phase;
    logic [27:0] eff_width;

    // Leading edge lands on the (fine)th ns of the cycle; the fall word is
    // its complement, so the high time is always width*4 ns.
    function automatic logic [3:0] rise_word(input logic [1:0] fine);
        logic [3:0] w;
        case (fine)
            2'd0:    w = 4'b1111;
            2'd1:    w = 4'b1110;
            2'd2:    w = 4'b1100;
            default: w = 4'b1000;
        endcase
        return w;
    endfunction

    assign wr_ok = i_cfg_wr && ({1'b0, i_cfg_phase} < PH_LIM);

    always_comb begin
        wr_width = i_cfg_width;
        if (i_cfg_width == 28'd0) begin
            wr_width = 28'd1;
        end else if (i_cfg_width >= PER) begin
            wr_width = PER_M1;
        end
    end

    always_comb begin
        state_nx      = state_q;
        ep_nx         = ep_q;
        cnt_nx        = cnt_q;
        fine_nx       = fine_q;
        act_phase_nx  = act_phase_q;
        act_width_nx  = act_width_q;
        pend_phase_nx = pend_phase_q;
        pend_width_nx = pend_width_q;
        pend_nx       = pend_q;
        word_nx       = 4'b0000;
        epoch_nx      = 1'b0;
        ack_nx        = 1'b0;
        err_nx        = i_cfg_wr && !wr_ok;
        eff_phase     = act_phase_q;
        eff_width     = act_width_q;

        if (!i_en) begin
            state_nx = ST_OFF;
            ep_nx    = 28'd0;
            cnt_nx   = 28'd0;
        end else begin
            if (state_q == ST_OFF || ep_q == PER_M1) begin
                ep_nx = 28'd0;
            end else begin
                ep_nx = ep_q + 28'd1;
            end
            epoch_nx = (ep_nx == 28'd0);

            // Config applied at the boundary governs this epoch's pulse
            // straight away, so coarse 0 can rise on the o_epoch cycle.
            if (epoch_nx && pend_q) begin
                act_phase_nx = pend_phase_q;
                act_width_nx = pend_width_q;
                pend_nx      = 1'b0;
                ack_nx       = 1'b1;
                eff_phase    = pend_phase_q;
                eff_width    = pend_width_q;
            end

            case (state_q)
                ST_HIGH: begin
                    // In-flight pulse owns the output until its fall word;
                    // a coarse match during that time is ignored.
                    if (cnt_q == 28'd1) begin
                        word_nx  = ~rise_word(fine_q);
                        cnt_nx   = 28'd0;
                        state_nx = ST_IDLE;
                    end else begin
                        word_nx = 4'b1111;
                        cnt_nx  = cnt_q - 28'd1;
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                    if (ep_nx == eff_phase[29:2]) begin
                        word_nx  = rise_word(eff_phase[1:0]);
                        fine_nx  = eff_phase[1:0];
                        cnt_nx   = eff_width;
                        state_nx = ST_HIGH;
                    end
                end
            endcase
        end

        // Sampled after the apply decision: a write landing on the wrap
        // edge waits for the following boundary.
        if (wr_ok) begin
            pend_phase_nx = i_cfg_phase;
            pend_width_nx = wr_width;
            pend_nx       = 1'b1;
        end
    end

    always_ff @(posedge i_pclk or posedge i_res) begin
        if (i_res) begin
            state_q      <= ST_OFF;
            ep_q         <= 28'd0;
            cnt_q        <= 28'd0;
            fine_q       <= 2'd0;
            act_phase_q  <= 30'd0;
            act_width_q  <= W_RST;
            pend_phase_q <= 30'd0;
            pend_width_q <= 28'd0;
            pend_q       <= 1'b0;
            o_dt4b       <= 4'b0000;
            o_active     <= 1'b0;
            o_epoch      <= 1'b0;
            o_cfg_ack    <= 1'b0;
            o_cfg_err    <= 1'b0;
        end else begin
            state_q      <= state_nx;
            ep_q         <= ep_nx;
            cnt_q        <= cnt_nx;
            fine_q       <= fine_nx;
            act_phase_q  <= act_phase_nx;
            act_width_q  <= act_width_nx;
            pend_phase_q <= pend_phase_nx;
            pend_width_q <= pend_width_nx;
            pend_q       <= pend_nx;
            o_dt4b       <= word_nx;
            o_active     <= (word_nx != 4'b0000);
            o_epoch      <= epoch_nx;
            o_cfg_ack    <= ack_nx;
            o_cfg_err    <= err_nx;
        end
    end

endmodule

// File: tb/tb_pps_gen.sv
// Bench for pps_gen with PERIOD=100, WIDTH_CYC=10. A time-based model
// (pulse described by its absolute rise time, fine offset and width) is
// compared against the DUT every cycle; directed steps also pin literal
// words from the pulse-shaping rules.

module tb_pps_gen;

    localparam int unsigned PER   = 100;
    localparam int unsigned W_RST = 10;

    logic        clk = 1'b0;
    logic        i_res = 1'b1;
    logic        i_en = 1'b0;
    logic        i_cfg_wr = 1'b0;
    logic [29:0] i_cfg_phase = '0;
    logic [27:0] i_cfg_width = '0;
    logic        o_cfg_ack, o_cfg_err, o_epoch, o_active;
    logic [3:0]  o_dt4b;

    int checks = 0;
    int errors = 0;

    pps_gen #(.PERIOD(PER), .WIDTH_CYC(W_RST)) dut (
        .i_pclk      (clk),
        .i_res       (i_res),
        .i_en        (i_en),
        .i_cfg_wr    (i_cfg_wr),
        .i_cfg_phase (i_cfg_phase),
        .i_cfg_width (i_cfg_width),
        .o_cfg_ack   (o_cfg_ack),
        .o_cfg_err   (o_cfg_err),
        .o_epoch     (o_epoch),
        .o_dt4b      (o_dt4b),
        .o_active    (o_active)
    );

    always #2 clk = ~clk;

    // ---------------- behavioural model ----------------
    int unsigned m_t = 0, m_ep = 0;
    int unsigned m_act_ph = 0, m_act_w = W_RST;
    int unsigned m_pend_ph = 0, m_pend_w = 0;
    int unsigned m_rise_t = 0, m_p_fine = 0, m_p_w = 0;
    int unsigned m_ph, m_w;
    bit          m_run = 0, m_pend = 0, m_live = 0;
    logic [3:0]  m_rm;
    logic [3:0]  e_word = 4'b0;
    bit          e_epoch = 0, e_ack = 0, e_err = 0, e_active = 0;
    bit          started = 0;

    always @(posedge clk) begin
        m_t++;
        if (i_res) begin
            m_run = 0; m_ep = 0; m_act_ph = 0; m_act_w = W_RST;
            m_pend = 0; m_live = 0;
            e_word = 4'b0; e_epoch = 0; e_ack = 0; e_err = 0; e_active = 0;
        end else begin
            m_ph  = int'(i_cfg_phase);
            m_w   = int'(i_cfg_width);
            e_err = i_cfg_wr && (m_ph >= 4 * PER);
            e_ack = 0; e_epoch = 0; e_word = 4'b0;
            if (!i_en) begin
                m_run = 0; m_ep = 0; m_live = 0;
            end else begin
                m_ep    = m_run ? (m_ep + 1) % PER : 0;
                m_run   = 1;
                e_epoch = (m_ep == 0);
                if (e_epoch && m_pend) begin
                    m_act_ph = m_pend_ph; m_act_w = m_pend_w; m_pend = 0; e_ack = 1;
                end
                if (m_live && m_t > m_rise_t + m_p_w) m_live = 0;
                if (!m_live && m_ep == m_act_ph / 4) begin
                    m_live = 1; m_rise_t = m_t; m_p_fine = m_act_ph % 4; m_p_w = m_act_w;
                end
                if (m_live) begin
                    m_rm = 4'(4'hF << m_p_fine);
                    if (m_t == m_rise_t)               e_word = m_rm;
                    else if (m_t < m_rise_t + m_p_w)   e_word = 4'hF;
                    else                               e_word = ~m_rm;
                end
            end
            e_active = (e_word != 4'b0);
            if (i_cfg_wr && !e_err) begin
                m_pend    = 1;
                m_pend_ph = m_ph;
                m_pend_w  = (m_w == 0) ? 1 : ((m_w >= PER) ? PER - 1 : m_w);
            end
        end
        started = 1;
    end

    // ---------------- per-cycle compare ----------------
    logic [7:0] cmp_got, cmp_exp;
    always @(negedge clk) begin
        if (started) begin
            cmp_got = {o_epoch, o_cfg_ack, o_cfg_err, o_active, o_dt4b};
            cmp_exp = i_res ? 8'h00 : {e_epoch, e_ack, e_err, e_active, e_word};
            checks++;
            if (cmp_got !== cmp_exp) begin
                errors++;
                $display("FAIL cycle_cmp t=%0d got {ep,ack,err,act,dt}=%b required %b", m_t, cmp_got, cmp_exp);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got %b required %b", nm, got, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input int unsigned ph, input int unsigned w);
        i_cfg_wr    = 1'b1;
        i_cfg_phase = 30'(ph);
        i_cfg_width = 28'(w);
        step(1);
        i_cfg_wr    = 1'b0;
    endtask

    task automatic wait_epoch();
        bit seen = 0;
        for (int i = 0; i < 3 * PER; i++) begin
            step(1);
            if (o_epoch) begin
                seen = 1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wait_epoch no o_epoch within %0d cycles", 3 * PER);
        end
    endtask

    // ---------------- stimulus ----------------
    int unsigned r;
    initial begin
        step(3);
        chk("reset_outputs", {o_epoch, o_cfg_ack, o_cfg_err, o_active, o_dt4b}, 8'h00);
        i_res = 1'b0;
        step(2);

        // default config: coarse 0, 10-cycle pulse starting with o_epoch
        i_en = 1'b1;
        wait_epoch();
        chk("first_epoch_word", {4'b0, o_dt4b}, 8'h0F);
        chk("first_epoch_noack", {7'b0, o_cfg_ack}, 8'h00);
        step(9);
        chk("default_last_high", {4'b0, o_dt4b}, 8'h0F);
        step(1);
        chk("default_fall", {3'b0, o_active, o_dt4b}, 8'h00);

        // phase 37 ns (coarse 9, fine 1), width 5
        step(10);
        wr(37, 5);
        wait_epoch();
        chk("ack_37", {7'b0, o_cfg_ack}, 8'h01);
        step(9);
        chk("rise_37", {4'b0, o_dt4b}, 8'h0E);
        chk("model_rise_37", {4'b0, e_word}, 8'h0E);
        step(4);
        chk("mid_37", {4'b0, o_dt4b}, 8'h0F);
        step(1);
        chk("fall_37", {3'b0, o_active, o_dt4b}, 8'h11);
        chk("model_fall_37", {4'b0, e_word}, 8'h01);
        step(1);
        chk("after_37", {4'b0, o_dt4b}, 8'h00);

        // phase 398 (coarse 99, fine 2), pulse crosses the wrap
        wr(398, 10);
        wait_epoch();
        chk("ack_398", {7'b0, o_cfg_ack}, 8'h01);
        step(99);
        chk("rise_398", {3'b0, o_epoch, o_dt4b}, 8'h0C);
        step(1);
        chk("wrap_mid_398", {3'b0, o_epoch, o_dt4b}, 8'h1F);
        step(9);
        chk("fall_398", {4'b0, o_dt4b}, 8'h03);
        chk("model_fall_398", {4'b0, e_word}, 8'h03);
        step(1);
        chk("after_398", {4'b0, o_dt4b}, 8'h00);
        step(89);
        chk("rise_398_again", {4'b0, o_dt4b}, 8'h0C);

        // out-of-range phase rejected
        wr(400, 0);
        chk("err_400", {6'b0, o_cfg_err, o_cfg_ack}, 8'h02);
        step(1);
        chk("err_400_single", {7'b0, o_cfg_err}, 8'h00);

        // width 0 clamps to a one-cycle pulse (coarse 11, fine 1)
        step(19);
        wr(45, 0);
        wait_epoch();
        chk("ack_45", {7'b0, o_cfg_ack}, 8'h01);
        step(11);
        chk("rise_45", {4'b0, o_dt4b}, 8'h0E);
        step(1);
        chk("fall_45", {3'b0, o_active, o_dt4b}, 8'h11);

        // two writes in one epoch: last wins
        wr(8, 3);
        wr(12, 2);
        wait_epoch();
        step(2);
        chk("first_write_dropped", {4'b0, o_dt4b}, 8'h00);
        step(1);
        chk("rise_12", {4'b0, o_dt4b}, 8'h0F);
        step(2);
        chk("fall_12", {3'b0, o_active, o_dt4b}, 8'h00);

        // write on the wrap edge: applied one boundary later
        step(94);
        wr(16, 4);
        chk("wrap_write_noack", {6'b0, o_epoch, o_cfg_ack}, 8'h02);
        wait_epoch();
        chk("wrap_write_ack", {7'b0, o_cfg_ack}, 8'h01);
        step(4);
        chk("rise_16", {4'b0, o_dt4b}, 8'h0F);

        // disable mid-pulse, pending kept over the outage
        step(1);
        i_en = 1'b0;
        step(1);
        chk("disable_zero", {3'b0, o_active, o_dt4b}, 8'h00);
        wr(20, 6);
        step(3);
        i_en = 1'b1;
        step(1);
        chk("reenable_epoch_ack", {6'b0, o_epoch, o_cfg_ack}, 8'h03);
        step(5);
        chk("rise_20", {4'b0, o_dt4b}, 8'h0F);
        step(6);
        chk("fall_20", {3'b0, o_active, o_dt4b}, 8'h00);

        // randomized traffic against the model
        for (int c = 0; c < 20000; c++) begin
            i_res = 1'b0;
            r = $urandom_range(0, 4999);
            if (r == 0) i_res = 1'b1;
            if ($urandom_range(0, 299) == 0) i_en = ~i_en;
            i_cfg_wr = ($urandom_range(0, 39) == 0);
            i_cfg_phase = 30'($urandom_range(0, 450));
            case ($urandom_range(0, 3))
                0:       i_cfg_width = 28'd0;
                1:       i_cfg_width = 28'($urandom_range(1, 20));
                2:       i_cfg_width = 28'($urandom_range(90, 200));
                default: i_cfg_width = 28'($urandom_range(1, 99));
            endcase
            step(1);
        end
        i_res = 1'b0;
        i_cfg_wr = 1'b0;
        i_en = 1'b1;

        // async reset in the middle of a pulse
        wr(0, 50);
        wait_epoch();
        wait_epoch();
        step(10);
        chk("pre_reset_high", {3'b0, o_active, o_dt4b}, 8'h1F);
        i_res = 1'b1;
        #1;
        chk("async_reset", {o_epoch, o_cfg_ack, o_cfg_err, o_active, o_dt4b}, 8'h00);
        step(2);
        i_res = 1'b0;
        step(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pps_gen.md
# pps_gen

Programmable 1PPS reference generator for self-test and calibration of the PPS phase-measurement path. Runs on the 250 MHz pixel-rate clock and emits a 4-bit parallel word per cycle for an external 1 GHz (500 MHz DDR) LVDS serializer, giving 1 ns edge placement. Phase offset and pulse width are written through a shadow-register handshake and take effect only at an epoch boundary, so the measured output never sees a truncated or doubled pulse.

## Interface
- PERIOD, 250000000, epoch length in i_pclk cycles (1 s at 250 MHz); legal range 8..2^28-1
- WIDTH_CYC, 25000000, reset-time pulse width in cycles (100 ms)
- i_pclk  in  1  250 MHz clock, sole clock
- i_res  in  1  reset, asynchronous, active-high
- i_en  in  1  generator enable
- i_cfg_wr  in  1  one-cycle config write strobe
- i_cfg_phase  in  30  rising-edge offset from epoch start, 1 ns units
- i_cfg_width  in  28  high time, i_pclk cycles (4 ns units)
- o_cfg_ack  out  1  one-cycle pulse when pending config becomes active
- o_cfg_err  out  1  one-cycle pulse when a write is rejected
- o_epoch  out  1  one-cycle pulse on the first cycle of every epoch
- o_dt4b  out  4  serializer word; bit 0 is transmitted first (earliest ns)
- o_active  out  1  high on every cycle o_dt4b is non-zero

## Operation
- Epoch counter r_ep, 28 bits, counts 0..PERIOD-1 and wraps to 0 while i_en=1; held at 0 while i_en=0.
- Active config: coarse = phase[29:2], fine = phase[1:0], width. Reset: phase 0, width WIDTH_CYC.
- Write: i_cfg_wr with i_cfg_phase < 4*PERIOD is accepted into the pending register and sets pending flag; otherwise o_cfg_err pulses next cycle and the pending register is unchanged. Later accepted writes overwrite pending (last wins).
- Width clamp on acceptance: 0 -> 1; >= PERIOD -> PERIOD-1.
- Apply: on the cycle r_ep wraps to 0 (or the first epoch cycle after i_en rises) with pending set, pending is copied to active, pending is cleared, o_cfg_ack pulses in the same cycle as o_epoch. A write in the same cycle as the wrap is not applied at that wrap; it is applied at the next one.
- Pulse shaping: when r_ep == coarse, rise word is emitted: fine 0 -> 1111, 1 -> 1110, 2 -> 1100, 3 -> 1000. A width down-counter loads width and decrements each cycle; middle words are 1111; when the counter expires, fall word = ~rise word (fine 0 -> 0000, 1 -> 0001, 2 -> 0011, 3 -> 0111). High time is exactly width*4 ns for every fine value.
- Width counter is independent of r_ep: a pulse extending past the epoch wrap completes normally. A new config applied at the wrap does not alter an in-flight pulse.
- i_en falling: o_dt4b forced to 0000 on the next cycle, any in-flight pulse aborted, width counter cleared, r_ep reset to 0; pending config retained.

## Timing
- All outputs registered; reset values: o_dt4b 0000, o_epoch 0, o_cfg_ack 0, o_cfg_err 0, o_active 0.
- o_epoch rises on the cycle after i_en first seen high, then every PERIOD cycles.
- Rise word appears exactly coarse cycles after the o_epoch cycle (coarse 0 -> same cycle as o_epoch).
- Fall word appears exactly width cycles after the rise word; o_active high from rise-word cycle through the last cycle before the fall word, plus the fall cycle if the fall word is non-zero.
- o_cfg_err: 1 cycle after the offending strobe. o_cfg_ack: coincident with o_epoch.
- Reset mid-pulse: all outputs 0 immediately (async), active config returns to reset values, pending cleared.

## Test plan
- PERIOD=100, WIDTH_CYC=10, enable after reset -> o_epoch every 100 cycles; 1111 for 10 cycles starting with o_epoch; no ack.
- Write phase=37 ns, width=5 mid-epoch -> ack at next o_epoch; rise 1110 at epoch+9, 1111 x4, fall 0001 at epoch+14; serialized high time 20 ns.
- Write phase=398, width=10 -> rise 1100 at epoch+99, pulse wraps into next epoch, fall 0011 at next-epoch+9; following pulse unaffected.
- Write phase=400 -> o_cfg_err one cycle later, no ack, output unchanged; width=0 accepted -> one-cycle pulse; two writes in one epoch -> only second applied.
- Write coincident with the wrap cycle -> not applied at that o_epoch, applied (ack) at the following one.
- Drop i_en mid-pulse -> 0000 next cycle, o_active 0; re-enable -> o_epoch after one cycle, pending config applied with ack; assert i_res mid-pulse -> all outputs 0 immediately.
